// File: rtl/cpu_gregs_mp_pkg.sv
// Shared register-file defaults and helpers for cpu_gregs_mp and its write-select slice.
// Mirrors the CPU-wide width constants so every file elaborates from one source.
package cpu_gregs_mp_pkg;

    localparam int unsigned CPU_XLEN          = 32;
    localparam int unsigned CPU_GREG_COUNT    = 32;
    localparam int unsigned CPU_GREGIDX_WIDTH = 5;
    localparam int unsigned CPU_GREG_NREAD    = 2;
    localparam int unsigned CPU_GREG_NWRITE   = 2;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/cpu_gregs_wsel.sv
// Resolves all write ports and the scoreboard controls against one register index:
// effective-write hit, winning data (highest port wins) and the post-update busy bit.
module cpu_gregs_wsel
    import cpu_gregs_mp_pkg::*;
#(
    parameter int unsigned XLEN   = CPU_XLEN,
    parameter int unsigned IDXW   = CPU_GREGIDX_WIDTH,
    parameter int unsigned NWRITE = CPU_GREG_NWRITE
) (
    input  logic [IDXW-1:0]        idx_i,
    input  logic                   cur_busy_i,
    input  logic [NWRITE-1:0]      rd_wen_i,
    input  logic [NWRITE*IDXW-1:0] rd_idx_i,
    input  logic [NWRITE*XLEN-1:0] rd_dat_i,
    input  logic                   mark_en_i,
    input  logic [IDXW-1:0]        mark_idx_i,
    input  logic                   flush_i,
    output logic                   hit_o,
    output logic [XLEN-1:0]        dat_o,
    output logic                   busy_o
);

    always_comb begin
        hit_o = 1'b0;
        dat_o = '0;
        // ascending scan lets the highest-numbered matching port overwrite earlier ones
        for (int unsigned j = 0; j < NWRITE; j++) begin
            if (rd_wen_i[j] && (rd_idx_i[j*IDXW +: IDXW] == idx_i) && (idx_i != '0)) begin
                hit_o = 1'b1;
                dat_o = rd_dat_i[j*XLEN +: XLEN];
            end
        end

        busy_o = cur_busy_i & ~hit_o;
        if (mark_en_i && (mark_idx_i == idx_i)) begin
            busy_o = 1'b1;
        end
        if (flush_i || (idx_i == '0)) begin
            busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/cpu_gregs_mp.sv
// Multi-port general register file with registered reads, same-cycle write bypass
// and a per-register busy scoreboard; x0 reads zero and is never busy.
module cpu_gregs_mp
    import cpu_gregs_mp_pkg::*;
#(
    parameter int unsigned XLEN      = CPU_XLEN,
    parameter int unsigned REG_COUNT = CPU_GREG_COUNT,
    parameter int unsigned IDXW      = CPU_GREGIDX_WIDTH,
    parameter int unsigned NREAD     = CPU_GREG_NREAD,
    parameter int unsigned NWRITE    = CPU_GREG_NWRITE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREAD*IDXW-1:0]  rs_idx,
    output logic [NREAD*XLEN-1:0]  rs_dat,
    output logic [NREAD-1:0]       rs_busy,
    input  logic [NWRITE-1:0]      rd_wen,
    input  logic [NWRITE*IDXW-1:0] rd_idx,
    input  logic [NWRITE*XLEN-1:0] rd_dat,
    input  logic                   mark_en,
    input  logic [IDXW-1:0]        mark_idx,
    input  logic                   flush
);

    if (REG_COUNT < 2 || !is_pow2(REG_COUNT)) begin : g_bad_count
        $error("cpu_gregs_mp: REG_COUNT must be a power of two >= 2");
    end
    if (IDXW != $clog2(REG_COUNT)) begin : g_bad_idxw
        $error("cpu_gregs_mp: IDXW must equal log2(REG_COUNT)");
    end
    if (NREAD < 1 || NREAD > 4) begin : g_bad_nread
        $error("cpu_gregs_mp: NREAD must be in 1..4");
    end
    if (NWRITE < 1 || NWRITE > 2) begin : g_bad_nwrite
        $error("cpu_gregs_mp: NWRITE must be in 1..2");
    end

    logic [XLEN-1:0]       regs_q [REG_COUNT];
    logic [REG_COUNT-1:0]  busy_q, busy_d;
    logic [REG_COUNT-1:0]  wr_hit;
    logic [XLEN-1:0]       wr_dat [REG_COUNT];
    logic [NREAD*XLEN-1:0] rs_dat_q, rs_dat_d;
    logic [NREAD-1:0]      rs_busy_q, rs_busy_d;

    for (genvar r = 0; r < REG_COUNT; r++) begin : g_reg
        cpu_gregs_wsel #(
            .XLEN   (XLEN),
            .IDXW   (IDXW),
            .NWRITE (NWRITE)
        ) u_wsel (
            .idx_i      (IDXW'(r)),
            .cur_busy_i (busy_q[r]),
            .rd_wen_i   (rd_wen),
            .rd_idx_i   (rd_idx),
            .rd_dat_i   (rd_dat),
            .mark_en_i  (mark_en),
            .mark_idx_i (mark_idx),
            .flush_i    (flush),
            .hit_o      (wr_hit[r]),
            .dat_o      (wr_dat[r]),
            .busy_o     (busy_d[r])
        );
    end

    // Read ports see the post-update state, so data and busy are bypassed identically.
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [IDXW-1:0] idx;
        logic            hit;
        logic [XLEN-1:0] wdat;

        assign idx = rs_idx[k*IDXW +: IDXW];

        cpu_gregs_wsel #(
            .XLEN   (XLEN),
            .IDXW   (IDXW),
            .NWRITE (NWRITE)
        ) u_wsel (
            .idx_i      (idx),
            .cur_busy_i (busy_q[idx]),
            .rd_wen_i   (rd_wen),
            .rd_idx_i   (rd_idx),
            .rd_dat_i   (rd_dat),
            .mark_en_i  (mark_en),
            .mark_idx_i (mark_idx),
            .flush_i    (flush),
            .hit_o      (hit),
            .dat_o      (wdat),
            .busy_o     (rs_busy_d[k])
        );

        assign rs_dat_d[k*XLEN +: XLEN] = hit ? wdat : regs_q[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < REG_COUNT; r++) begin
                regs_q[r] <= '0;
            end
            busy_q    <= '0;
            rs_dat_q  <= '0;
            rs_busy_q <= '0;
        end else begin
            for (int unsigned r = 0; r < REG_COUNT; r++) begin
                if (wr_hit[r]) begin
                    regs_q[r] <= wr_dat[r];
                end
            end
            busy_q    <= busy_d;
            rs_dat_q  <= rs_dat_d;
            rs_busy_q <= rs_busy_d;
        end
    end

    assign rs_dat  = rs_dat_q;
    assign rs_busy = rs_busy_q;

endmodule

// File: tb/tb_cpu_gregs_mp.sv
// Self-checking bench for cpu_gregs_mp: directed scenarios plus random traffic
// checked against an array-based architectural model of registers and busy bits.
module tb_cpu_gregs_mp;

    localparam int XL = 32;
    localparam int RC = 32;
    localparam int IW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR*IW-1:0] rs_idx = '0;
    logic [NR*XL-1:0] rs_dat;
    logic [NR-1:0]    rs_busy;
    logic [NW-1:0]    rd_wen = '0;
    logic [NW*IW-1:0] rd_idx = '0;
    logic [NW*XL-1:0] rd_dat = '0;
    logic             mark_en = 1'b0;
    logic [IW-1:0]    mark_idx = '0;
    logic             flush = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [XL-1:0] m_regs [RC];
    bit            m_busy [RC];
    logic [XL-1:0] exp_dat [NR];
    bit            exp_busy [NR];

    always #5 clk = ~clk;

    cpu_gregs_mp #(
        .XLEN      (XL),
        .REG_COUNT (RC),
        .IDXW      (IW),
        .NREAD     (NR),
        .NWRITE    (NW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_idx   (rs_idx),
        .rs_dat   (rs_dat),
        .rs_busy  (rs_busy),
        .rd_wen   (rd_wen),
        .rd_idx   (rd_idx),
        .rd_dat   (rd_dat),
        .mark_en  (mark_en),
        .mark_idx (mark_idx),
        .flush    (flush)
    );

    task automatic model_reset();
        for (int r = 0; r < RC; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 0;
        end
    endtask

    task automatic idle();
        rd_wen   = '0;
        rd_idx   = '0;
        rd_dat   = '0;
        mark_en  = 1'b0;
        mark_idx = '0;
        flush    = 1'b0;
    endtask

    // Architectural effect of one clock: writes in port order, then mark, then flush;
    // reads observe the resulting state.
    task automatic step();
        int idx;
        for (int j = 0; j < NW; j++) begin
            idx = int'(rd_idx[j*IW +: IW]);
            if (rd_wen[j] && idx != 0) begin
                m_regs[idx] = rd_dat[j*XL +: XL];
                m_busy[idx] = 0;
            end
        end
        if (mark_en && mark_idx != 0) m_busy[int'(mark_idx)] = 1;
        if (flush) for (int r = 0; r < RC; r++) m_busy[r] = 0;
        for (int k = 0; k < NR; k++) begin
            idx = int'(rs_idx[k*IW +: IW]);
            exp_dat[k]  = m_regs[idx];
            exp_busy[k] = m_busy[idx];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input int a, input int b);
        rs_idx[0*IW +: IW] = IW'(a);
        rs_idx[1*IW +: IW] = IW'(b);
    endtask

    task automatic set_wr(input int j, input int idx, input logic [XL-1:0] d);
        rd_wen[j]          = 1'b1;
        rd_idx[j*IW +: IW] = IW'(idx);
        rd_dat[j*XL +: XL] = d;
    endtask

    task automatic test_reset();
        // power-on reset held: outputs must be zero
        #1;
        n_cmp++;
        if (rs_dat !== '0 || rs_busy !== '0) begin
            n_err++;
            $display("FAIL reset_hold: rs_dat=%h rs_busy=%b want 0/0", rs_dat, rs_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        // dirty some state, then pulse reset mid-cycle
        idle();
        set_wr(0, 11, 32'h1111_2222);
        set_wr(1, 12, 32'h3333_4444);
        mark_en = 1'b1; mark_idx = 5'd13;
        set_rs(11, 13);
        step();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rs_dat !== '0 || rs_busy !== '0) begin
            n_err++;
            $display("FAIL reset_async: rs_dat=%h rs_busy=%b want 0/0", rs_dat, rs_busy);
        end
        #3;
        rst_n = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (rs_dat !== '0 || rs_busy !== '0) begin
            n_err++;
            $display("FAIL reset_release: rs_dat=%h rs_busy=%b want 0/0", rs_dat, rs_busy);
        end
        @(posedge clk); #1;
        for (int r = 0; r < RC; r += 2) begin
            set_rs(r, r + 1);
            step();
            for (int k = 0; k < NR; k++) begin
                n_cmp++;
                if (rs_dat[k*XL +: XL] !== '0 || rs_busy[k] !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_readall x%0d: dat=%h busy=%b want 0/0",
                             r + k, rs_dat[k*XL +: XL], rs_busy[k]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        set_wr(0, 5, 32'hDEAD_BEEF);
        set_rs(0, 0);
        step();
        idle();
        set_rs(5, 5);
        step();
        for (int k = 0; k < NR; k++) begin
            n_cmp++;
            if (rs_dat[k*XL +: XL] !== 32'hDEAD_BEEF || rs_dat[k*XL +: XL] !== exp_dat[k]) begin
                n_err++;
                $display("FAIL write_read port%0d: got %h want %h", k, rs_dat[k*XL +: XL], 32'hDEAD_BEEF);
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        set_wr(0, 7, 32'h0000_1234);
        set_rs(7, 5);
        step();
        n_cmp++;
        if (rs_dat[0 +: XL] !== 32'h0000_1234) begin
            n_err++;
            $display("FAIL bypass: got %h want %h", rs_dat[0 +: XL], 32'h0000_1234);
        end
        n_cmp++;
        if (rs_dat[XL +: XL] !== exp_dat[1]) begin
            n_err++;
            $display("FAIL bypass_other: got %h want %h", rs_dat[XL +: XL], exp_dat[1]);
        end
        idle();
    endtask

    task automatic test_priority();
        idle();
        set_wr(0, 3, 32'h0000_AAAA);
        set_wr(1, 3, 32'h0000_5555);
        set_rs(3, 0);
        step();
        n_cmp++;
        if (rs_dat[0 +: XL] !== 32'h0000_5555) begin
            n_err++;
            $display("FAIL prio_bypass: got %h want %h", rs_dat[0 +: XL], 32'h0000_5555);
        end
        idle();
        set_wr(0, 0, 32'h0000_FFFF);
        set_rs(3, 0);
        step();
        n_cmp++;
        if (rs_dat[0 +: XL] !== 32'h0000_5555) begin
            n_err++;
            $display("FAIL prio_store: got %h want %h", rs_dat[0 +: XL], 32'h0000_5555);
        end
        n_cmp++;
        if (rs_dat[XL +: XL] !== '0 || rs_busy[1] !== 1'b0) begin
            n_err++;
            $display("FAIL x0_bypass: dat=%h busy=%b want 0/0", rs_dat[XL +: XL], rs_busy[1]);
        end
        idle();
        set_rs(0, 0);
        step();
        n_cmp++;
        if (rs_dat !== '0) begin
            n_err++;
            $display("FAIL x0_store: got %h want 0", rs_dat);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        mark_en = 1'b1; mark_idx = 5'd9;
        set_rs(9, 4);
        step();
        n_cmp++;
        if (rs_busy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL sb_mark: busy=%b want 1", rs_busy[0]);
        end
        idle();
        set_rs(9, 9);
        step();
        n_cmp++;
        if (rs_busy !== 2'b11) begin
            n_err++;
            $display("FAIL sb_hold: busy=%b want 11", rs_busy);
        end
        idle();
        set_wr(1, 9, 32'h0909_0909);
        set_rs(9, 9);
        step();
        n_cmp++;
        if (rs_busy !== 2'b00 || rs_dat[0 +: XL] !== 32'h0909_0909) begin
            n_err++;
            $display("FAIL sb_clear: busy=%b dat=%h want 00/09090909", rs_busy, rs_dat[0 +: XL]);
        end
        idle();
        set_wr(0, 9, 32'h9999_0000);
        mark_en = 1'b1; mark_idx = 5'd9;
        set_rs(9, 0);
        step();
        n_cmp++;
        if (rs_busy[0] !== 1'b1 || rs_dat[0 +: XL] !== 32'h9999_0000) begin
            n_err++;
            $display("FAIL sb_mark_write: busy=%b dat=%h want 1/99990000", rs_busy[0], rs_dat[0 +: XL]);
        end
        idle();
        mark_en = 1'b1; mark_idx = 5'd4;
        set_rs(4, 9);
        step();
        idle();
        flush = 1'b1;
        mark_en = 1'b1; mark_idx = 5'd4;
        set_wr(0, 20, 32'h2020_2020);
        set_rs(4, 9);
        step();
        n_cmp++;
        if (rs_busy !== 2'b00) begin
            n_err++;
            $display("FAIL sb_flush: busy=%b want 00", rs_busy);
        end
        idle();
        set_rs(20, 4);
        step();
        n_cmp++;
        if (rs_dat[0 +: XL] !== 32'h2020_2020 || rs_busy[1] !== 1'b0) begin
            n_err++;
            $display("FAIL sb_flush_write: dat=%h busy=%b want 20202020/0", rs_dat[0 +: XL], rs_busy[1]);
        end
        idle();
        mark_en = 1'b1; mark_idx = 5'd0;
        set_rs(0, 0);
        step();
        n_cmp++;
        if (rs_busy !== 2'b00 || rs_dat !== '0) begin
            n_err++;
            $display("FAIL sb_mark_x0: busy=%b dat=%h want 00/0", rs_busy, rs_dat);
        end
        idle();
    endtask

    task automatic test_random();
        int lim;
        for (int c = 0; c < 400; c++) begin
            lim = ($urandom_range(0, 1) == 0) ? 7 : RC - 1;
            for (int j = 0; j < NW; j++) begin
                rd_wen[j]          = ($urandom_range(0, 2) != 0);
                rd_idx[j*IW +: IW] = IW'($urandom_range(0, lim));
                rd_dat[j*XL +: XL] = $urandom;
            end
            mark_en  = ($urandom_range(0, 2) == 0);
            mark_idx = IW'($urandom_range(0, lim));
            flush    = ($urandom_range(0, 19) == 0);
            set_rs($urandom_range(0, lim), $urandom_range(0, lim));
            step();
            for (int k = 0; k < NR; k++) begin
                n_cmp++;
                if (rs_dat[k*XL +: XL] !== exp_dat[k] || rs_busy[k] !== exp_busy[k]) begin
                    n_err++;
                    $display("FAIL random c%0d port%0d: dat=%h busy=%b want %h/%b",
                             c, k, rs_dat[k*XL +: XL], rs_busy[k], exp_dat[k], exp_busy[k]);
                end
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_read();
        test_bypass();
        test_priority();
        test_scoreboard();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
